mem_bus_arbiter: RTL and testbench

// - Shares the single core memory bus between the fetch stage (instruction

---
 rtl/mem_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter for the shared core memory bus: data has priority,
// a starvation counter guarantees fetch progress. Watchdog: ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                iresp_ok,
  output logic [DATA_W-1:0]   iresp_data,
  input  logic                dreq_valid,
  input  logic                dreq_write,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [2:0]          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_data,
  output logic                dresp_ok,
  output logic [DATA_W-1:0]   dresp_data,
  output logic                creq_valid,
  output logic                creq_write,
  output logic [ADDR_W-1:0]   creq_addr,
  output logic [2:0]          creq_size,
  output logic [DATA_W/8-1:0] creq_strobe,
  output logic [DATA_W-1:0]   creq_data,
  input  logic                cresp_ok,
  input  logic [DATA_W-1:0]   cresp_data,
  output logic                arb_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [1:0]        state;
  logic [SW-1:0]     starve_cnt;
  logic              blk;
  logic              iv;
  logic              dv;
  logic              starved;
  logic              grant_d;
  logic              grant_i;
  logic              tmo;
  logic              done;
  logic [DATA_W-1:0] rdata;

  // The ok cycle doubles as the bus turnaround cycle: no grant is made.
  always_comb begin
    blk     = iresp_ok | dresp_ok;
    iv      = ireq_valid & ~blk;
    dv      = dreq_valid & ~blk;
    starved = starve_cnt >= SW'(STARVE_LIMIT);
    grant_d = (state == IDLE) & dv & (~iv | ~starved);
    grant_i = (state == IDLE) & iv & ~grant_d;
    done    = (state != IDLE) & (cresp_ok | tmo);
    rdata   = tmo ? '0 : cresp_data;
  end

  assign creq_valid = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_cnt;

  assign tmo = (state != IDLE) & ~cresp_ok
             & (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt  <= '0;
      arb_err <= 1'b0;
    end else begin
      arb_err <= tmo;
      if (state == IDLE || cresp_ok || tmo)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WW'(1);
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT_CYCLES;
  assign tmo            = 1'b0;
  assign arb_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      iresp_ok    <= 1'b0;
      iresp_data  <= '0;
      dresp_ok    <= 1'b0;
      dresp_data  <= '0;
      creq_write  <= 1'b0;
      creq_addr   <= '0;
      creq_size   <= '0;
      creq_strobe <= '0;
      creq_data   <= '0;
    end else begin
      iresp_ok <= 1'b0;
      dresp_ok <= 1'b0;
      if (state == IDLE) begin
        unique case (1'b1)
          grant_d: begin
            state       <= BUSY_D;
            creq_write  <= dreq_write;
            creq_addr   <= dreq_addr;
            creq_size   <= dreq_size;
            creq_strobe <= dreq_write ? dreq_strobe : '0;
            creq_data   <= dreq_write ? dreq_data : '0;
            if (!iv)
              starve_cnt <= '0;
            else if (!starved)
              starve_cnt <= starve_cnt + SW'(1);
          end
          grant_i: begin
            state       <= BUSY_I;
            creq_write  <= 1'b0;
            creq_addr   <= ireq_addr;
            creq_size   <= 3'd2;
            creq_strobe <= '0;
            creq_data   <= '0;
            starve_cnt  <= '0;
          end
          default: ;
        endcase
      end else if (done) begin
        state <= IDLE;
        if (state == BUSY_I) begin
          iresp_ok   <= 1'b1;
          iresp_data <= rdata;
        end else begin
          dresp_ok   <= 1'b1;
          dresp_data <= rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected
// bus grants and responses; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ok;
  logic [63:0] iresp_data;
  logic        dreq_valid;
  logic        dreq_write;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_ok;
  logic [63:0] dresp_data;
  logic        creq_valid;
  logic        creq_write;
  logic [63:0] creq_addr;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ok;
  logic [63:0] cresp_data;
  logic        arb_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    logic [63:0] addr;
    logic        w;
    logic [2:0]  size;
    logic [7:0]  strb;
    logic [63:0] data;
    logic        err;
  } ev_t;

  ev_t  q[$];
  logic prev_cv = 1'b0;

  mem_bus_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .ireq_valid  (ireq_valid),
    .ireq_addr   (ireq_addr),
    .iresp_ok    (iresp_ok),
    .iresp_data  (iresp_data),
    .dreq_valid  (dreq_valid),
    .dreq_write  (dreq_write),
    .dreq_addr   (dreq_addr),
    .dreq_size   (dreq_size),
    .dreq_strobe (dreq_strobe),
    .dreq_data   (dreq_data),
    .dresp_ok    (dresp_ok),
    .dresp_data  (dresp_data),
    .creq_valid  (creq_valid),
    .creq_write  (creq_write),
    .creq_addr   (creq_addr),
    .creq_size   (creq_size),
    .creq_strobe (creq_strobe),
    .creq_data   (creq_data),
    .cresp_ok    (cresp_ok),
    .cresp_data  (cresp_data),
    .arb_err     (arb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected event kind %0d at %0t", kind, $time);
      return;
    end
    e = q.pop_front();
    chk("event kind", kind, e.kind);
    if (kind == 0) begin
      chk("creq_addr", creq_addr, e.addr);
      chk("creq_write", creq_write, e.w);
      chk("creq_size", creq_size, e.size);
      chk("creq_strobe", creq_strobe, e.strb);
      chk("creq_data", creq_data, e.data);
    end else if (kind == 1) begin
      chk("iresp_data", iresp_data, e.data);
      chk("arb_err", arb_err, e.err);
    end else begin
      chk("dresp_data", dresp_data, e.data);
      chk("arb_err", arb_err, e.err);
    end
  endtask

  always @(negedge clk) begin
    if (creq_valid && !prev_cv) take(0);
    if (iresp_ok) take(1);
    if (dresp_ok) take(2);
    if (arb_err && !iresp_ok && !dresp_ok) begin
      checks++;
      errors++;
      $display("FAIL stray arb_err: got 1 expected 0 at %0t", $time);
    end
    prev_cv = creq_valid;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_g(input logic [63:0] a, input logic w,
                        input logic [2:0] s, input logic [7:0] b,
                        input logic [63:0] d);
    ev_t e;
    e.kind = 0; e.addr = a; e.w = w; e.size = s;
    e.strb = b; e.data = d; e.err = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_r(input int k, input logic [63:0] d,
                        input logic err);
    ev_t e;
    e.kind = k; e.addr = '0; e.w = 1'b0; e.size = '0;
    e.strb = '0; e.data = d; e.err = err;
    q.push_back(e);
  endtask

  task automatic respond(input int dly, input logic [63:0] d);
    int n = 0;
    while (!creq_valid && n < 50) begin
      tick();
      n++;
    end
    if (!creq_valid) begin
      checks++;
      errors++;
      $display("FAIL creq_valid wait: got 0 expected 1 at %0t", $time);
      return;
    end
    tick(dly);
    cresp_data = d;
    cresp_ok   = 1'b1;
    tick();
    cresp_ok   = 1'b0;
    cresp_data = '0;
  endtask

  task automatic drained(input string nm);
    chk(nm, q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn      = 1'b0;
    ireq_valid  = 1'b0;
    ireq_addr   = '0;
    dreq_valid  = 1'b0;
    dreq_write  = 1'b0;
    dreq_addr   = '0;
    dreq_size   = '0;
    dreq_strobe = '0;
    dreq_data   = '0;
    cresp_ok    = 1'b0;
    cresp_data  = '0;
    #2;
    chk("reset creq_valid", creq_valid, 0);
    chk("reset iresp_ok", iresp_ok, 0);
    chk("reset dresp_ok", dresp_ok, 0);
    chk("reset arb_err", arb_err, 0);
    chk("reset creq_addr", creq_addr, 0);
    chk("reset dresp_data", dresp_data, 0);
    tick(2);
    resetn = 1'b1;
    tick();

    // isolated fetch
    push_g(64'h8000_0000, 1'b0, 3'd2, 8'h00, 64'h0);
    push_r(1, 64'h13, 1'b0);
    ireq_addr  = 64'h8000_0000;
    ireq_valid = 1'b1;
    tick();
    chk("grant latency", creq_valid, 1);
    respond(3, 64'h13);
    chk("iresp_ok latency", iresp_ok, 1);
    ireq_valid = 1'b0;
    tick(3);
    drained("fetch drained");

    // simultaneous requests: data first
    push_g(64'h200, 1'b0, 3'd3, 8'h00, 64'h0);
    push_r(2, 64'hAA, 1'b0);
    push_g(64'h100, 1'b0, 3'd2, 8'h00, 64'h0);
    push_r(1, 64'hBB, 1'b0);
    ireq_addr   = 64'h100;
    dreq_addr   = 64'h200;
    dreq_size   = 3'd3;
    dreq_strobe = 8'hFF;
    dreq_write  = 1'b0;
    dreq_data   = '0;
    ireq_valid  = 1'b1;
    dreq_valid  = 1'b1;
    respond(1, 64'hAA);
    dreq_valid = 1'b0;
    respond(2, 64'hBB);
    ireq_valid = 1'b0;
    tick(3);
    drained("simul drained");

    // starvation: D,D,D,D then I
    ireq_addr   = 64'h300;
    ireq_valid  = 1'b1;
    dreq_strobe = 8'h00;
    dreq_size   = 3'd3;
    for (int k = 0; k < 4; k++) begin
      push_g(64'h400 + 64'(8 * k), 1'b0, 3'd3, 8'h00, 64'h0);
      push_r(2, 64'(k + 1), 1'b0);
    end
    push_g(64'h300, 1'b0, 3'd2, 8'h00, 64'h0);
    push_r(1, 64'h77, 1'b0);
    push_g(64'h500, 1'b0, 3'd3, 8'h00, 64'h0);
    push_r(2, 64'h88, 1'b0);
    for (int k = 0; k < 4; k++) begin
      dreq_addr  = 64'h400 + 64'(8 * k);
      dreq_valid = 1'b1;
      respond(1, 64'(k + 1));
      dreq_valid = 1'b0;
      tick();
    end
    dreq_addr  = 64'h500;
    dreq_valid = 1'b1;
    respond(1, 64'h77);
    chk("starve_cnt cleared", dut.starve_cnt, 0);
    ireq_valid = 1'b0;
    respond(1, 64'h88);
    dreq_valid = 1'b0;
    tick(3);
    drained("starve drained");

    // store then read with nonzero strobe
    push_g(64'h8, 1'b1, 3'd3, 8'hFF, 64'hDEAD);
    push_r(2, 64'h1234, 1'b0);
    push_g(64'h10, 1'b0, 3'd2, 8'h00, 64'h0);
    push_r(2, 64'hCAFE, 1'b0);
    dreq_write  = 1'b1;
    dreq_addr   = 64'h8;
    dreq_size   = 3'd3;
    dreq_strobe = 8'hFF;
    dreq_data   = 64'hDEAD;
    dreq_valid  = 1'b1;
    respond(1, 64'h1234);
    dreq_valid = 1'b0;
    tick();
    dreq_write  = 1'b0;
    dreq_addr   = 64'h10;
    dreq_size   = 3'd2;
    dreq_strobe = 8'h0F;
    dreq_data   = '0;
    dreq_valid  = 1'b1;
    respond(1, 64'hCAFE);
    dreq_valid = 1'b0;
    tick(3);
    drained("store drained");

    // cresp_ok while idle is ignored
    cresp_data = 64'h5;
    cresp_ok   = 1'b1;
    tick();
    cresp_ok   = 1'b0;
    cresp_data = '0;
    tick(3);
    chk("idle cresp no ok", {iresp_ok, dresp_ok}, 0);
    drained("idle drained");

    // reset two cycles after a data grant
    push_g(64'h40, 1'b0, 3'd3, 8'h00, 64'h0);
    dreq_addr  = 64'h40;
    dreq_size  = 3'd3;
    dreq_valid = 1'b1;
    tick();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("async drop creq_valid", creq_valid, 0);
    chk("async clear creq_addr", creq_addr, 0);
    chk("reset no dresp_ok", dresp_ok, 0);
    dreq_valid = 1'b0;
    tick(2);
    resetn = 1'b1;
    cresp_ok = 1'b1;
    tick();
    cresp_ok = 1'b0;
    tick(4);
    chk("post reset idle", creq_valid, 0);
    drained("reset drained");

    // bus usable after reset
    push_g(64'h80, 1'b0, 3'd2, 8'h00, 64'h0);
    push_r(1, 64'h99, 1'b0);
    ireq_addr  = 64'h80;
    ireq_valid = 1'b1;
    respond(2, 64'h99);
    ireq_valid = 1'b0;
    tick(3);
    drained("refetch drained");

`ifdef ARB_TIMEOUT_EN
    begin
      int n;
      push_g(64'h60, 1'b0, 3'd3, 8'h00, 64'h0);
      push_r(2, 64'h0, 1'b1);
      push_g(64'h68, 1'b0, 3'd3, 8'h00, 64'h0);
      push_r(2, 64'h42, 1'b0);
      dreq_addr  = 64'h60;
      dreq_valid = 1'b1;
      tick();
      n = 0;
      while (!dresp_ok && n < 400) begin
        tick();
        n++;
      end
      dreq_valid = 1'b0;
      chk("timeout busy cycles", n, 255);
      tick();
      dreq_addr  = 64'h68;
      dreq_valid = 1'b1;
      respond(1, 64'h42);
      dreq_valid = 1'b0;
      tick(3);
      drained("timeout drained");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
